// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub with the carry chain cut into
// STAGES registered ripple segments, valid/ready flow control.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad
    $error("WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  // r_a/r_b carry the not-yet-added upper slices forward (skew),
  // r_s collects finished lower sum slices (deskew).
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_ovf;

  // The whole pipe moves as one: it advances unless the
  // output slot is occupied and not being taken.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; Cin is irrelevant then.
  assign w_beff = Sub ? ~B : B;
  assign w_c0   = Sub | Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_snext;
    logic             w_ci;
    logic             w_vi;
    logic [SEG:0]     w_c;
    logic [SEG-1:0]   w_sum;

    if (k == 0) begin : g_in
      assign w_a  = A;
      assign w_b  = w_beff;
      assign w_s  = '0;
      assign w_ci = w_c0;
      assign w_vi = in_valid;
    end else begin : g_mid
      assign w_a  = r_a[k-1];
      assign w_b  = r_b[k-1];
      assign w_s  = r_s[k-1];
      assign w_ci = r_c[k-1];
      assign w_vi = r_v[k-1];
    end

    assign w_c[0] = w_ci;

    for (genvar j = 0; j < SEG; j++) begin : g_fa
      full_adder u_fa (
        .i_a (w_a[k*SEG+j]),
        .i_b (w_b[k*SEG+j]),
        .i_c (w_c[j]),
        .o_s (w_sum[j]),
        .o_c (w_c[j+1])
      );
    end

    // Merge this stage's slice into the partial sum word.
    always_comb begin
      w_snext = w_s;
      w_snext[k*SEG +: SEG] = w_sum;
    end

    // Stage register: captures operands, partial sum, carry, valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end else if (w_adv) begin
        r_a[k] <= w_a;
        r_b[k] <= w_b;
        r_s[k] <= w_snext;
        r_c[k] <= w_c[SEG];
        r_v[k] <= w_vi;
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Signed overflow: carry into MSB differs from carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_c[SEG-1] ^ w_c[SEG];
        end
      end
    end
  end

  assign Sum       = r_s[STAGES-1];
  assign Cout      = r_c[STAGES-1];
  assign Ovf       = r_ovf;
  assign out_valid = r_v[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed 8-bit/2-stage vectors plus random
// 32-bit streams at 1, 4 and 8 stages against a golden model.

module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a, b;
  logic       cin, sub, iv, ordy;
  logic       irdy;
  logic [7:0] sum;
  logic       cout, ovf, ov;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sub       (sub),
    .in_valid  (iv),
    .in_ready  (irdy),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf),
    .out_valid (ov),
    .out_ready (ordy)
  );

  logic        rst32;
  logic [31:0] a32, b32;
  logic        cin32, sub32, iv32;
  logic        ordy32 [3];
  logic        irdy32 [3];
  logic [31:0] s32    [3];
  logic        co32   [3];
  logic        of32   [3];
  logic        ov32   [3];

  for (genvar g = 0; g < 3; g++) begin : g_r
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    pipelined_adder #(.WIDTH(32), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst32),
      .A         (a32),
      .B         (b32),
      .Cin       (cin32),
      .Sub       (sub32),
      .in_valid  (iv32),
      .in_ready  (irdy32[g]),
      .Sum       (s32[g]),
      .Cout      (co32[g]),
      .Ovf       (of32[g]),
      .out_valid (ov32[g]),
      .out_ready (ordy32[g])
    );
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] pa, input logic [7:0] pb,
                     input logic pc, input logic ps, input logic pv);
    a   = pa;
    b   = pb;
    cin = pc;
    sub = ps;
    iv  = pv;
  endtask

  function automatic logic [10:0] o8();
    return {ov, cout, ovf, sum};
  endfunction

  function automatic logic [33:0] gold(input logic [31:0] ga,
                                       input logic [31:0] gb,
                                       input logic gc,
                                       input logic gs);
    logic [31:0] be;
    logic [32:0] f;
    logic        vo;
    be = gs ? ~gb : gb;
    f  = {1'b0, ga} + {1'b0, be} + {32'd0, gs | gc};
    vo = (ga[31] == be[31]) && (f[31] != ga[31]);
    return {f[32], vo, f[31:0]};
  endfunction

  logic [33:0] sb [3][$];
  int          acc [3];

  task automatic step32();
    logic [33:0] e;
    for (int g = 0; g < 3; g++) begin
      if (ov32[g] && ordy32[g]) begin
        if (sb[g].size() == 0) begin
          chk($sformatf("rnd%0d_extra", g), 64'd1, 64'd0);
        end else begin
          e = sb[g].pop_front();
          chk($sformatf("rnd%0d_res", g),
              {30'd0, co32[g], of32[g], s32[g]}, {30'd0, e});
        end
      end
      if (iv32 && irdy32[g]) begin
        sb[g].push_back(gold(a32, b32, cin32, sub32));
        acc[g]++;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    ordy  = 1'b1;
    rst32 = 1'b1;
    a32   = '0;
    b32   = '0;
    cin32 = 1'b0;
    sub32 = 1'b0;
    iv32  = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ordy32[g] = 1'b1;
      acc[g]    = 0;
    end

    put(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_a", o8(), 64'h0);
    tick();
    chk("rst_b", o8(), 64'h0);

    rst = 1'b0;
    tick();
    chk("lat_early", ov, 1'b0);
    put(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    chk("add_ovf", o8(), {1'b1, 1'b0, 1'b1, 8'h80});
    put(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
    tick();
    chk("add_cout", o8(), {1'b1, 1'b1, 1'b0, 8'h00});
    put(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    chk("sub_neg", o8(), {1'b1, 1'b0, 1'b0, 8'hFE});
    iv = 1'b0;
    tick();
    chk("sub_ovf", o8(), {1'b1, 1'b1, 1'b1, 8'h7F});
    tick();
    chk("bubble", ov, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      put(8'(i), 8'(i), 1'b0, 1'b0, 1'b1);
      tick();
      if (i >= 2) begin
        chk($sformatf("strm%0d", i - 1), {ov, sum},
            {1'b1, 8'(2 * (i - 1))});
      end
    end
    iv = 1'b0;
    tick();
    chk("strm16", {ov, sum}, {1'b1, 8'h20});
    tick();
    chk("strm_end", ov, 1'b0);

    put(8'h10, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    put(8'h20, 8'h02, 1'b0, 1'b0, 1'b1);
    tick();
    ordy = 1'b0;
    put(8'h30, 8'h03, 1'b0, 1'b0, 1'b1);
    #1;
    chk("stall_rdy", irdy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out", o8(), {1'b1, 1'b0, 1'b0, 8'h11});
      chk("stall_rdy", irdy, 1'b0);
    end
    ordy = 1'b1;
    tick();
    chk("rel_1", o8(), {1'b1, 1'b0, 1'b0, 8'h22});
    iv = 1'b0;
    tick();
    chk("rel_2", o8(), {1'b1, 1'b0, 1'b0, 8'h33});
    tick();
    chk("rel_end", ov, 1'b0);

    put(8'h40, 8'h04, 1'b0, 1'b0, 1'b1);
    tick();
    put(8'h50, 8'h05, 1'b0, 1'b0, 1'b1);
    tick();
    iv  = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid", o8(), 64'h0);
    rst = 1'b0;
    tick();
    chk("rst_gone", ov, 1'b0);
    put(8'h0A, 8'h05, 1'b1, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    tick();
    chk("post_rst", o8(), {1'b1, 1'b0, 1'b0, 8'h10});
    tick();
    chk("post_end", ov, 1'b0);

    tick();
    rst32 = 1'b0;
    for (int cy = 0; cy < 8000; cy++) begin
      if (acc[0] >= 1000 && acc[1] >= 1000 && acc[2] >= 1000) break;
      a32   = $urandom;
      b32   = $urandom;
      cin32 = 1'($urandom_range(0, 1));
      sub32 = 1'($urandom_range(0, 1));
      iv32  = ($urandom_range(0, 3) != 0);
      for (int g = 0; g < 3; g++) begin
        ordy32[g] = ($urandom_range(0, 3) != 0);
      end
      #1;
      step32();
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rnd%0d_acc", g), 64'(acc[g] >= 1000), 64'd1);
    end

    iv32 = 1'b0;
    for (int g = 0; g < 3; g++) ordy32[g] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      step32();
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rnd%0d_left", g), 64'(sb[g].size()), 64'd0);
      chk($sformatf("rnd%0d_idle", g), ov32[g], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
